// File: rtl/cmos_gate_trio.sv
// Switch-level NOT/AND/OR cell built from pmos/nmos on supply rails, plus a
// clocked shell that registers the gate outputs and counts vector changes.
module cmos_gate_trio #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             A,
  input  logic             B,
  output wire              out_NOT,
  output wire              out_AND,
  output wire              out_OR,
  input  logic             clk,
  input  logic             rst,
  output logic             out_NOT_q,
  output logic             out_AND_q,
  output logic             out_OR_q,
  output logic [CNT_W-1:0] chg_cnt
);

  supply1 vdd;
  supply0 gnd;

  wire nand_n;
  wire nand_mid;
  wire nor_n;
  wire nor_mid;

  // NOT: complementary pair
  pmos p_not (out_NOT, vdd, A);
  nmos n_not (out_NOT, gnd, A);

  // NAND: parallel pull-up, series pull-down
  pmos p_nand_a (nand_n, vdd, A);
  pmos p_nand_b (nand_n, vdd, B);
  nmos n_nand_a (nand_n, nand_mid, A);
  nmos n_nand_b (nand_mid, gnd, B);

  pmos p_and_inv (out_AND, vdd, nand_n);
  nmos n_and_inv (out_AND, gnd, nand_n);

  // NOR: series pull-up, parallel pull-down
  pmos p_nor_a (nor_mid, vdd, A);
  pmos p_nor_b (nor_n, nor_mid, B);
  nmos n_nor_a (nor_n, gnd, A);
  nmos n_nor_b (nor_n, gnd, B);

  pmos p_or_inv (out_OR, vdd, nor_n);
  nmos n_or_inv (out_OR, gnd, nor_n);

  logic [2:0] vec;
  logic [2:0] vec_q;

  always_comb begin
    vec = {out_NOT, out_AND, out_OR};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q   <= 3'b100;
      chg_cnt <= '0;
    end else begin
      vec_q <= vec;
      if (vec != vec_q) chg_cnt <= chg_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    {out_NOT_q, out_AND_q, out_OR_q} = vec_q;
  end

endmodule

// File: tb/tb_cmos_gate_trio.sv
// Randomized and directed checks of cmos_gate_trio against a truth-table model;
// a second instance with a 2-bit counter exercises counter wrap.
module tb_cmos_gate_trio;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       A   = 1'b0;
  logic       B   = 1'b0;
  wire        out_NOT, out_AND, out_OR;
  logic       out_NOT_q, out_AND_q, out_OR_q;
  logic [7:0] chg_cnt;
  wire        n2, a2, o2;
  logic       nq2, aq2, oq2;
  logic [1:0] chg_cnt2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned m_cnt   = 0;
  logic [2:0]  m_q     = 3'bxxx;
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  cmos_gate_trio dut (
    .A(A), .B(B), .out_NOT(out_NOT), .out_AND(out_AND), .out_OR(out_OR),
    .clk(clk), .rst(rst),
    .out_NOT_q(out_NOT_q), .out_AND_q(out_AND_q), .out_OR_q(out_OR_q),
    .chg_cnt(chg_cnt)
  );

  cmos_gate_trio #(.CNT_W(2)) dut2 (
    .A(A), .B(B), .out_NOT(n2), .out_AND(a2), .out_OR(o2),
    .clk(clk), .rst(rst),
    .out_NOT_q(nq2), .out_AND_q(aq2), .out_OR_q(oq2),
    .chg_cnt(chg_cnt2)
  );

  function automatic logic [2:0] ref_vec(input int a, input int b);
    int n, x, o;
    n = 1 - a;
    x = a * b;
    o = (a + b > 0) ? 1 : 0;
    return {n[0], x[0], o[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_comb(input string tag);
    chk({tag, "_comb"}, {29'd0, out_NOT, out_AND, out_OR}, {29'd0, ref_vec(int'(A), int'(B))});
    chk({tag, "_comb2"}, {29'd0, n2, a2, o2}, {29'd0, ref_vec(int'(A), int'(B))});
  endtask

  task automatic step(input logic a, input logic b, input logic r, input string tag);
    logic [2:0] nv;
    @(negedge clk);
    A = a; B = b; rst = r;
    #1 check_comb({tag, "_pre"});
    @(posedge clk);
    nv = ref_vec(int'(a), int'(b));
    if (r) begin
      m_q = 3'b100; m_cnt = 0; m_valid = 1'b1;
    end else begin
      if (m_valid && nv != m_q) m_cnt++;
      m_q = nv;
    end
    #1;
    check_comb({tag, "_post"});
    if (m_valid) begin
      chk({tag, "_q"}, {29'd0, out_NOT_q, out_AND_q, out_OR_q}, {29'd0, m_q});
      chk({tag, "_q2"}, {29'd0, nq2, aq2, oq2}, {29'd0, m_q});
      chk({tag, "_cnt"}, {24'd0, chg_cnt}, m_cnt % 256);
      chk({tag, "_cnt2"}, {30'd0, chg_cnt2}, m_cnt % 4);
    end
  endtask

  initial begin
    // combinational behaviour with no clock edge involved
    A = 1'b1; B = 1'b1;
    #1 chk("comb_11_first", {29'd0, out_NOT, out_AND, out_OR}, 32'h3);
    A = 1'b0; B = 1'b0;
    #1 chk("sweep_00", {29'd0, out_NOT, out_AND, out_OR}, 32'h4);
    A = 1'b0; B = 1'b1;
    #1 chk("sweep_01", {29'd0, out_NOT, out_AND, out_OR}, 32'h5);
    A = 1'b1; B = 1'b0;
    #1 chk("sweep_10", {29'd0, out_NOT, out_AND, out_OR}, 32'h1);
    A = 1'b1; B = 1'b1;
    #1 chk("sweep_11", {29'd0, out_NOT, out_AND, out_OR}, 32'h3);

    step(1'b1, 1'b1, 1'b1, "rst11");
    chk("rst_cnt_zero", {24'd0, chg_cnt}, 32'd0);
    step(1'b1, 1'b1, 1'b0, "first11");
    chk("first11_cnt_one", {24'd0, chg_cnt}, 32'd1);

    step(1'b1, 1'b0, 1'b1, "rst10");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "hold10");
    chk("hold10_cnt", {24'd0, chg_cnt}, 32'd1);

    for (int i = 0; i < 6; i++) step(~A, 1'b0, 1'b0, "toggleA");
    chk("toggle_cnt", {24'd0, chg_cnt}, 32'd7);
    chk("toggle_cnt2_wrapped", {30'd0, chg_cnt2}, 32'd3);

    step(~A, 1'b0, 1'b1, "midrst");
    chk("midrst_q", {29'd0, out_NOT_q, out_AND_q, out_OR_q}, 32'h4);
    step(1'b0, 1'b1, 1'b0, "resume");
    chk("resume_cnt", {24'd0, chg_cnt}, 32'd1);

    for (int i = 0; i < 300; i++) begin
      logic ra, rb, rr;
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 19) == 0);
      step(ra, rb, rr, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
